// File: rtl/lfsr_arbiter.sv
// Round-robin burst arbiter that streams words from a 16-bit Fibonacci LFSR to the granted requester.
// Optional build macro: LFSR_LOCKUP_GUARD_EN replaces an all-zero LFSR with SEED on the next edge.
module lfsr_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          BURST_LEN = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [15:0]        data,
  output logic               valid,
  input  logic               ready,
  input  logic               seed_load,
  input  logic [15:0]        seed_in,
  output logic               busy,
  output logic               burst_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      ptr_reg, ptr_next;
  logic [PW-1:0]      gidx_reg, gidx_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic [15:0]        lfsr_reg, lfsr_next;
  logic               bd_reg, bd_next;

  logic [15:0]        lfsr_step;
  logic [PW-1:0]      cand [NUM_REQ];
  logic [PW-1:0]      pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] gnt_dec;
  logic [PW-1:0]      ptr_inc;
  logic               last_word;

  assign lfsr_step = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  // cand[k] is the requester index k positions after the pointer, wrapped modulo NUM_REQ
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [PW:0] sum;
      assign sum      = {1'b0, ptr_reg} + (PW+1)'(gi);
      assign cand[gi] = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : sum[PW-1:0];
    end
  endgenerate

  // Walk from the farthest candidate back to the nearest so the nearest requester wins
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[i];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_dec
      assign gnt_dec[gi] = (pick_idx == PW'(gi));
    end
  endgenerate

  assign ptr_inc   = (gidx_reg == PW'(NUM_REQ - 1)) ? '0 : gidx_reg + 1'b1;
  assign last_word = (cnt_reg == 8'(BURST_LEN - 1));

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gidx_next  = gidx_reg;
    gnt_next   = gnt_reg;
    cnt_next   = cnt_reg;
    lfsr_next  = lfsr_reg;
    bd_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (seed_load) begin
          lfsr_next = seed_in;
        end
        if (pick_found) begin
          state_next = BURST;
          gidx_next  = pick_idx;
          gnt_next   = gnt_dec;
          cnt_next   = '0;
        end
      end
      BURST: begin
        // valid is high throughout BURST, so ready alone marks an accepted word
        if (ready) begin
          lfsr_next = lfsr_step;
        end
        if (ready && last_word) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = ptr_inc;
          bd_next    = 1'b1;
        end else if (!req[gidx_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = ptr_inc;
        end else if (ready) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
`ifdef LFSR_LOCKUP_GUARD_EN
    // An explicit seed load in IDLE still takes precedence over the recovery value
    if ((lfsr_reg == 16'h0000) && !((state_reg == IDLE) && seed_load)) begin
      lfsr_next = SEED;
    end
`endif
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      gidx_reg  <= '0;
      gnt_reg   <= '0;
      cnt_reg   <= '0;
      lfsr_reg  <= SEED;
      bd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gidx_reg  <= gidx_next;
      gnt_reg   <= gnt_next;
      cnt_reg   <= cnt_next;
      lfsr_reg  <= lfsr_next;
      bd_reg    <= bd_next;
    end
  end

  assign gnt        = gnt_reg;
  assign data       = lfsr_reg;
  assign valid      = (state_reg == BURST);
  assign busy       = (state_reg != IDLE);
  assign burst_done = bd_reg;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Bench for lfsr_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_lfsr_arbiter;

  localparam int          N    = 4;
  localparam int          BLEN = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         nReset;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [15:0]  data;
  logic         valid;
  logic         ready;
  logic         seed_load;
  logic [15:0]  seed_in;
  logic         busy;
  logic         burst_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner = -1 when no burst is running, words = words accepted so far
  int          m_owner;
  int          m_words;
  int          m_ptr;
  logic [15:0] m_lfsr;
  logic        m_done;

  always #5 clk = ~clk;

  lfsr_arbiter #(.NUM_REQ(N), .BURST_LEN(BLEN), .SEED(SEED)) dut (
    .clk(clk), .nReset(nReset), .req(req), .gnt(gnt), .data(data), .valid(valid),
    .ready(ready), .seed_load(seed_load), .seed_in(seed_in), .busy(busy), .burst_done(burst_done)
  );

  function automatic logic [15:0] nxt(input logic [15:0] v);
    logic fb;
    fb = ^(v & 16'hB400);
    return (v << 1) | 16'(fb);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_words = 0;
    m_ptr   = 0;
    m_lfsr  = SEED;
    m_done  = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] old;
    logic        was_idle;
    old      = m_lfsr;
    was_idle = (m_owner < 0);
    m_done   = 1'b0;
    if (was_idle) begin
      if (seed_load) m_lfsr = seed_in;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_words = 0;
        end
      end
    end else begin
      if (ready) m_lfsr = nxt(m_lfsr);
      if (ready && m_words == BLEN - 1) begin
        m_done  = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (ready) begin
        m_words++;
      end
    end
`ifdef LFSR_LOCKUP_GUARD_EN
    if (old == 16'h0000 && !(was_idle && seed_load)) m_lfsr = SEED;
`endif
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("data", 32'(data), 32'(m_lfsr));
    check("valid", 32'(valid), 32'(m_owner >= 0));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("burst_done", 32'(burst_done), 32'(m_done));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    nReset    = 1'b0;
    req       = '0;
    ready     = 1'b0;
    seed_load = 1'b0;
    seed_in   = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    nReset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] order [$];
    logic [N-1:0] last_g;
    int           pulses;

    // Single requester, full burst with ready held high
    do_reset();
    req = 4'b0001; ready = 1'b1;
    cycle();
    check("basic_gnt", 32'(gnt), 32'h1);
    check("basic_w0", 32'(data), 32'hACE1);
    cycle();
    check("basic_w1", 32'(data), 32'h59C3);
    cycle();
    check("basic_w2", 32'(data), 32'hB387);
    pulses = 0;
    cycle();
    req = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (burst_done) pulses++;
    end
    check("basic_pulses", 32'(pulses), 32'd1);
    check("basic_gnt_end", 32'(gnt), 32'h0);

    // Two requesters held: grants alternate with an idle gap between bursts
    do_reset();
    req = 4'b1010; ready = 1'b1;
    last_g = '0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (gnt != '0 && gnt != last_g) order.push_back(gnt);
      last_g = gnt;
    end
    check("rr_count", 32'(order.size() >= 3), 32'd1);
    check("rr_0", 32'((order.size() > 0) ? order[0] : '0), 32'h2);
    check("rr_1", 32'((order.size() > 1) ? order[1] : '0), 32'h8);
    check("rr_2", 32'((order.size() > 2) ? order[2] : '0), 32'h2);

    // Ready pattern 1,0,0,1 gives exactly two advances
    do_reset();
    req = 4'b0001; ready = 1'b0;
    cycle();
    ready = 1'b1; cycle();
    ready = 1'b0; cycle();
    check("hold_data", 32'(data), 32'h59C3);
    cycle();
    ready = 1'b1; cycle();
    check("two_adv", 32'(data), 32'hB387);
    ready = 1'b0; req = '0;
    cycle();
    cycle();

    // Abort after two accepts; pointer moves past the aborted requester
    do_reset();
    req = 4'b0100; ready = 1'b1;
    cycle();
    cycle();
    cycle();
    req = '0;
    cycle();
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_bd", 32'(burst_done), 32'h0);
    req = 4'b1111;
    cycle();
    check("abort_next", 32'(gnt), 32'h8);
    req = '0; ready = 1'b0;
    cycle();
    cycle();

    // Seed load together with a grant, then an ignored load mid-burst
    do_reset();
    req = 4'b0001; ready = 1'b1; seed_load = 1'b1; seed_in = 16'h1234;
    cycle();
    check("seed_gnt", 32'(gnt), 32'h1);
    check("seed_w0", 32'(data), 32'h1234);
    seed_in = 16'h5555;
    cycle();
    check("seed_ign", 32'(data), 32'(nxt(16'h1234)));
    seed_load = 1'b0; req = '0;
    cycle();
    cycle();

    // Zero seed: lockup behaviour depends on the build
    do_reset();
    seed_load = 1'b1; seed_in = 16'h0000;
    cycle();
    check("zero_load", 32'(data), 32'h0);
    seed_load = 1'b0;
    cycle();
`ifdef LFSR_LOCKUP_GUARD_EN
    check("zero_next", 32'(data), 32'hACE1);
`else
    check("zero_next", 32'(data), 32'h0);
`endif

    // Reset asserted in the middle of a burst
    do_reset();
    req = 4'b0010; ready = 1'b1;
    cycle();
    cycle();
    nReset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_gnt", 32'(gnt), 32'h0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 15));
      ready     = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 15) == 0);
      seed_in   = 16'($urandom_range(1, 65535));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
